// File: rtl/signed_display7_driver.sv
// Signed/unsigned binary to 7-segment driver: a serial double-dabble conversion
// followed by one formatting cycle that applies blanking, sign and overflow.
module signed_display7_driver #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic [WIDTH-1:0]          value,
  input  logic                      signed_mode,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [7*(DIGITS+1)-1:0]   seg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam int SW = 7 * (DIGITS + 1);

  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [63:0] max_mag();
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < DIGITS; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_MAG = max_mag();

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mag_q, mag_d;
  logic              neg_q, neg_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     seg_q, seg_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              cap_neg;
  logic [WIDTH-1:0]  cap_mag;
  logic              cap_ovf;
  logic [BW-1:0]     bcd_adj;
  logic [SW-1:0]     fmt_seg;

  // Capture-side magnitude; -2^(WIDTH-1) wraps to itself, read as unsigned.
  always_comb begin
    cap_neg = signed_mode & value[WIDTH-1];
    cap_mag = cap_neg ? (~value + WIDTH'(1)) : value;
    cap_ovf = {{(64-WIDTH){1'b0}}, cap_mag} > MAX_MAG;
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Scan from the top digit down; digits show once a nonzero digit was seen.
  always_comb begin
    int unsigned k;
    logic        seen;
    fmt_seg = '1;
    seen    = 1'b0;
    k       = 0;
    if (ovf_pend_q) begin
      for (int unsigned i = 0; i < DIGITS; i++) fmt_seg[7*i +: 7] = SEG_MINUS;
    end else begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        k = unsigned'(DIGITS) - 1 - i;
        if (bcd_q[4*k +: 4] != 4'd0) seen = 1'b1;
        if (seen || k == 0) fmt_seg[7*k +: 7] = seg7(bcd_q[4*k +: 4]);
      end
      fmt_seg[7*DIGITS +: 7] = neg_q ? SEG_MINUS : SEG_BLANK;
    end
  end

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    neg_d      = neg_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    seg_d      = seg_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          neg_d      = cap_neg;
          mag_d      = cap_mag;
          ovf_pend_d = cap_ovf;
          bcd_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
        mag_d = mag_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FORMAT;
      end
      FORMAT: begin
        seg_d   = fmt_seg;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      neg_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      seg_q      <= '1;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      neg_q      <= neg_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      seg_q      <= seg_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_signed_display7_driver.sv
// Bench for signed_display7_driver: directed vector table, random values against
// an arithmetic decimal model, and hand-written abort/overlap/back-to-back sequences.
module tb_signed_display7_driver;

  localparam logic [6:0] B  = 7'b1111111;
  localparam logic [6:0] M  = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        load5, sm5, busy5, done5, ovf5;
  logic [15:0] val5;
  logic [41:0] seg5;
  logic        load4, sm4, busy4, done4, ovf4;
  logic [15:0] val4;
  logic [34:0] seg4;

  signed_display7_driver #(.WIDTH(16), .DIGITS(5)) u_dut5 (
    .clock(clk), .reset(rst), .load(load5), .value(val5), .signed_mode(sm5),
    .busy(busy5), .done(done5), .overflow(ovf5), .seg(seg5)
  );

  signed_display7_driver #(.WIDTH(16), .DIGITS(4)) u_dut4 (
    .clock(clk), .reset(rst), .load(load4), .value(val4), .signed_mode(sm4),
    .busy(busy4), .done(done4), .overflow(ovf4), .seg(seg4)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [6:0] pat(input longint d);
    case (d)
      0: return S0;
      1: return S1;
      2: return S2;
      3: return S3;
      4: return S4;
      5: return S5;
      6: return S6;
      7: return S7;
      8: return S8;
      default: return S9;
    endcase
  endfunction

  // Returns {overflow, seg}; decimal digits from plain division.
  function automatic logic [42:0] model(input logic [15:0] v, input logic sm, input int digits);
    logic [41:0] s;
    longint      m, lim, p;
    logic        neg, ov;
    neg = sm & v[15];
    m   = neg ? (65536 - longint'(v)) : longint'(v);
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    ov = (m >= lim);
    s  = '0;
    p  = 1;
    for (int k = 0; k < digits; k++) begin
      if (ov)                   s[7*k +: 7] = M;
      else if (k == 0 || m >= p) s[7*k +: 7] = pat((m / p) % 10);
      else                      s[7*k +: 7] = B;
      p = p * 10;
    end
    s[7*digits +: 7] = (neg && !ov) ? M : B;
    return {ov, s};
  endfunction

  function automatic logic cur_done(input int sel);
    return (sel == 0) ? done5 : done4;
  endfunction
  function automatic logic cur_busy(input int sel);
    return (sel == 0) ? busy5 : busy4;
  endfunction
  function automatic logic cur_ovf(input int sel);
    return (sel == 0) ? ovf5 : ovf4;
  endfunction
  function automatic logic [41:0] cur_seg(input int sel);
    return (sel == 0) ? seg5 : {7'b0, seg4};
  endfunction

  task automatic run_conv(input int sel, input logic [15:0] v, input logic sm,
                          output int lat, output bit busy_ok);
    @(negedge clk);
    if (sel == 0) begin load5 = 1'b1; val5 = v; sm5 = sm; end
    else          begin load4 = 1'b1; val4 = v; sm4 = sm; end
    @(posedge clk);
    @(negedge clk);
    load5 = 1'b0; load4 = 1'b0;
    val5 = 16'($urandom); sm5 = 1'($urandom);
    val4 = 16'($urandom); sm4 = 1'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!cur_done(sel) && lat < 100) begin
      if (!cur_busy(sel)) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic check_conv(input int sel, input logic [15:0] v, input logic sm,
                            input logic [41:0] eseg, input logic eovf, input string name);
    int lat;
    bit bok;
    run_conv(sel, v, sm, lat, bok);
    chk({name, " latency"}, 64'(lat), 64'd17);
    chk({name, " busy_during"}, 64'(bok), 64'd1);
    chk({name, " busy_at_done"}, 64'(cur_busy(sel)), 64'd0);
    chk({name, " seg"}, 64'(cur_seg(sel)), 64'(eseg));
    chk({name, " ovf"}, 64'(cur_ovf(sel)), 64'(eovf));
    @(posedge clk);
    @(negedge clk);
    chk({name, " done_one_cycle"}, 64'(cur_done(sel)), 64'd0);
    chk({name, " seg_hold"}, 64'(cur_seg(sel)), 64'(eseg));
  endtask

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] v;
    logic        sm;
    logic [41:0] seg;
    logic        ovf;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    logic [42:0] exp;
    logic [15:0] v;
    logic        sm;
    int          pulses, first, second;

    rst = 1'b1;
    load5 = 1'b0; val5 = '0; sm5 = 1'b0;
    load4 = 1'b0; val4 = '0; sm4 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 64'(busy5), 64'd0);
    chk("reset done", 64'(done5), 64'd0);
    chk("reset ovf", 64'(ovf5), 64'd0);
    chk("reset seg5", 64'(seg5), 64'h3FF_FFFF_FFFF);
    chk("reset seg4", 64'(seg4), 64'h7_FFFF_FFFF);

    // Reset wins over a simultaneous load.
    load5 = 1'b1; val5 = 16'd77;
    @(posedge clk);
    @(negedge clk);
    chk("reset_vs_load busy", 64'(busy5), 64'd0);
    rst = 1'b0; load5 = 1'b0;

    vecs.push_back('{"u1234",  0, 16'd1234, 1'b0, {B, B, S1, S2, S3, S4}, 1'b0});
    vecs.push_back('{"sFFFF",  0, 16'hFFFF, 1'b1, {M, B, B, B, B, S1},   1'b0});
    vecs.push_back('{"uFFFF",  0, 16'hFFFF, 1'b0, {B, S6, S5, S5, S3, S5}, 1'b0});
    vecs.push_back('{"s8000",  0, 16'h8000, 1'b1, {M, S3, S2, S7, S6, S8}, 1'b0});
    vecs.push_back('{"zero",   0, 16'd0,    1'b0, {B, B, B, B, B, S0},   1'b0});
    vecs.push_back('{"u8000",  0, 16'h8000, 1'b0, {B, S3, S2, S7, S6, S8}, 1'b0});
    vecs.push_back('{"s7FFF",  0, 16'h7FFF, 1'b1, {B, S3, S2, S7, S6, S7}, 1'b0});
    vecs.push_back('{"s_m10",  0, 16'hFFF6, 1'b1, {M, B, B, B, S1, S0},  1'b0});
    vecs.push_back('{"u100",   0, 16'd100,  1'b0, {B, B, B, S1, S0, S0}, 1'b0});
    vecs.push_back('{"d4_10000", 1, 16'd10000, 1'b0, {7'b0, B, M, M, M, M},   1'b1});
    vecs.push_back('{"d4_9999",  1, 16'd9999,  1'b0, {7'b0, B, S9, S9, S9, S9}, 1'b0});
    vecs.push_back('{"d4_s_m1",  1, 16'hFFFF,  1'b1, {7'b0, M, B, B, B, S1},   1'b0});

    foreach (vecs[i])
      check_conv(vecs[i].sel, vecs[i].v, vecs[i].sm, vecs[i].seg, vecs[i].ovf, vecs[i].name);

    for (int i = 0; i < 40; i++) begin
      v  = 16'($urandom);
      sm = 1'($urandom);
      if (i % 4 == 0) v = 16'($urandom_range(0, 120));
      if (i % 4 == 1) v = 16'(16'hFFFF - 16'($urandom_range(0, 120)));
      exp = model(v, sm, 5);
      check_conv(0, v, sm, exp[41:0], exp[42], "rand5");
    end
    for (int i = 0; i < 20; i++) begin
      v  = (i % 2 == 0) ? 16'(9990 + $urandom_range(0, 20)) : 16'($urandom);
      sm = 1'($urandom);
      exp = model(v, sm, 4);
      check_conv(1, v, sm, exp[41:0], exp[42], "rand4");
    end

    // Load re-asserted at E5 while busy must be dropped.
    @(negedge clk);
    load5 = 1'b1; val5 = 16'd1234; sm5 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    load5 = 1'b0;
    pulses = 0; first = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 5) begin load5 = 1'b1; val5 = 16'd4321; end
      @(posedge clk);
      @(negedge clk);
      load5 = 1'b0;
      if (done5) begin
        pulses++;
        if (first < 0) begin
          first = cyc;
          chk("busy_load seg", 64'(seg5), 64'({B, B, S1, S2, S3, S4}));
        end
      end
    end
    chk("busy_load pulses", 64'(pulses), 64'd1);
    chk("busy_load done_at", 64'(first), 64'd17);

    // Reset at E8 aborts the conversion with no done and a blank display.
    @(negedge clk);
    load5 = 1'b1; val5 = 16'hFFF6; sm5 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load5 = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (cyc == 8) rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
    chk("abort busy", 64'(busy5), 64'd0);
    chk("abort seg", 64'(seg5), 64'h3FF_FFFF_FFFF);
    chk("abort ovf", 64'(ovf5), 64'd0);
    pulses = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (done5) pulses++;
    end
    chk("abort no_done", 64'(pulses), 64'd0);
    chk("abort seg_later", 64'(seg5), 64'h3FF_FFFF_FFFF);

    // Back-to-back: second load on the cycle right after the done pulse.
    @(negedge clk);
    load5 = 1'b1; val5 = 16'd42; sm5 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    load5 = 1'b0;
    pulses = 0; first = -1; second = -1;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      load5 = 1'b0;
      if (done5) begin
        pulses++;
        if (pulses == 1) begin
          first = cyc;
          load5 = 1'b1; val5 = 16'hFC18; sm5 = 1'b1;
        end else if (pulses == 2) begin
          second = cyc;
        end
      end
    end
    exp = model(16'hFC18, 1'b1, 5);
    chk("b2b pulses", 64'(pulses), 64'd2);
    chk("b2b first", 64'(first), 64'd17);
    chk("b2b second", 64'(second), 64'd35);
    chk("b2b seg", 64'(seg5), 64'(exp[41:0]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
